ahb_spi_flash_xip: RTL
======================

AHB_SPI_FLASH_XIP -- requirements
Module: ahb_spi_flash_xip

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, AHB address width.
REQ-002 SHALL have parameter CMD_READ, default 8'h03, SPI read opcode sent before the address.
REQ-003 SHALL have data width fixed at 32 bits.
REQ-004 SHALL run on one clock, with reset asynchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 ahbls_hready_resp  output  1  slave ready.
REQ-008 ahbls_hready  input  1  bus ready.
REQ-009 ahbls_hresp  output  1  error response.
REQ-010 ahbls_haddr  input  W_ADDR  address.
REQ-011 ahbls_hwrite  input  1  write flag.
REQ-012 ahbls_htrans  input  2  transfer type.
REQ-013 ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata  inputs  3/3/4/1/32  ignored.
REQ-014 ahbls_hrdata  output  32  read data.
REQ-015 spi_cs_n  output  1  flash chip select, active low.
REQ-016 spi_sck  output  1  SPI clock, mode 0.
REQ-017 spi_mosi  output  1  serial data to flash.
REQ-018 spi_miso  input  1  serial data from flash.

Function
REQ-019 SHALL treat an address phase as active when hready && htrans[1]; read if !hwrite, write otherwise.
REQ-020 SHALL accept an address phase only in states IDLE, DONE and ERR1.
REQ-021 SHALL, on an accepted read, latch addr = {haddr[23:2], 2'b00}; haddr[W_ADDR-1:24], haddr[1:0] and hsize are ignored.
REQ-022 SHALL have states: IDLE, SETUP, SHIFT, HOLD, DONE, ERR0, ERR1.
REQ-023 Transitions from IDLE, DONE and ERR1: accepted read -> SETUP; accepted write -> ERR0; no transfer -> IDLE.
REQ-024 SETUP lasts 1 clk: cs_n=0, sck=0, mosi=CMD_READ[7]; then -> SHIFT.
REQ-025 SHIFT lasts exactly 128 clks (64 bits x 2 clks per bit).
REQ-026 In SHIFT, sck SHALL be 0 on the first clk of each bit and 1 on the second clk (clk/2, mode 0).
REQ-027 mosi SHALL be updated only at the end of an sck-high clk.
REQ-028 The transmitted bit sequence SHALL be CMD_READ[7:0], then addr[23:0], MSB first; mosi SHALL be 0 during the 32 data bits.
REQ-029 miso SHALL be sampled at the end of each sck-high clk; only bits 33..64 are retained.
REQ-030 Received bytes b0..b3 (flash addr..addr+3, each MSB first) SHALL assemble as hrdata = {b3,b2,b1,b0}.
REQ-031 HOLD lasts 1 clk: cs_n=0, sck=0; then -> DONE.
REQ-032 DONE: cs_n=1, hready_resp=1, hresp=0, hrdata valid.
REQ-033 Read latency SHALL be hready_resp low for exactly 130 clks (SETUP + 128 SHIFT + HOLD), then high in DONE.
REQ-034 ERR0: hready_resp=0, hresp=1; -> ERR1 unconditionally.
REQ-035 ERR1: hready_resp=1, hresp=1; no SPI activity occurs for writes.
REQ-036 In IDLE: hready_resp=1, hresp=0, cs_n=1, sck=0, mosi=0.
REQ-037 hrdata SHALL be a register holding the last assembled word and SHALL change only on the HOLD->DONE transition.
REQ-038 Back-to-back reads accepted in DONE SHALL give cs_n high for exactly 1 clk between frames.
REQ-039 spi_cs_n, spi_sck and spi_mosi SHALL be driven directly from flops (glitch-free).
REQ-040 htrans IDLE/BUSY while not in IDLE/DONE/ERR1 SHALL have no effect.

Reset
REQ-041 While rst=1, outputs SHALL be: state IDLE, hready_resp=1, hresp=0, hrdata=0, cs_n=1, sck=0, mosi=0.
REQ-042 Assertion of rst mid-frame SHALL deassert cs_n asynchronously and abort the frame, with no response issued.
REQ-043 The first accepted transfer after reset release SHALL behave as from IDLE.

Verification
REQ-044 Read haddr=0x0000_1004, flash model holds bytes 11,22,33,44 at 0x1004 -> MOSI carries 03 00 10 04; hrdata=0x44332211 after 130 stall clks.
REQ-045 Read haddr=0xFF12_3457 -> address sent as 0x123454; hresp=0.
REQ-046 Write to any address -> ERR0 then ERR1 (hresp=1 both cycles, hready_resp 0 then 1); cs_n stays 1.
REQ-047 Two back-to-back reads (second address phase in DONE) -> two 64-bit frames separated by exactly 1 clk of cs_n=1; both words are correct.
REQ-048 Write immediately followed by read (read address phase in ERR1) -> error completes, then the read is served normally.
REQ-049 rst pulsed at SHIFT clk 50 -> cs_n=1 and sck=0 immediately; a later read of 0x0 returns the correct data.

Source files
------------

// File: rtl/ahb_spi_flash_xip.sv
// AHB-Lite slave that serves each 32-bit read with a single SPI READ (0x03-style) frame.
// Writes are refused with a two-cycle AHB error response and never touch the SPI bus.
module ahb_spi_flash_xip #(
    parameter int          W_ADDR   = 32,
    parameter logic [7:0]  CMD_READ = 8'h03
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ahbls_hready_resp,
    input  logic              ahbls_hready,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [31:0]       ahbls_hwdata,
    output logic [31:0]       ahbls_hrdata,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4,
        ERR0  = 3'd5,
        ERR1  = 3'd6
    } state_t;

    state_t      state_r, state_s;
    logic [6:0]  cnt_r, cnt_s;
    logic [31:0] tx_r, tx_s;
    logic [31:0] rx_r, rx_s;
    logic [31:0] hrdata_r, hrdata_s;
    logic        cs_n_r, cs_n_s;
    logic        sck_r, sck_s;
    logic        mosi_r, mosi_s;
    logic        hready_resp_r, hready_resp_s;
    logic        hresp_r, hresp_s;
    logic        accept_s;
    logic        unused_bits;

    assign unused_bits = ^{ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                           ahbls_hwdata, ahbls_haddr[W_ADDR-1:24], ahbls_haddr[1:0]};

    // Bytes arrive lowest address first; the bus word is little-endian.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Next-state, shift datapath and next values of every registered output.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        tx_s     = tx_r;
        rx_s     = rx_r;
        hrdata_s = hrdata_r;
        mosi_s   = mosi_r;
        accept_s = ahbls_hready && ahbls_htrans[1];
        case (state_r)
            IDLE, DONE, ERR1: begin
                if (accept_s) begin
                    if (ahbls_hwrite) begin
                        state_s = ERR0;
                    end else begin
                        state_s = SETUP;
                        tx_s    = {CMD_READ, ahbls_haddr[23:2], 2'b00};
                        mosi_s  = CMD_READ[7];
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s = SHIFT;
                cnt_s   = 7'd0;
            end
            SHIFT: begin
                cnt_s = cnt_r + 7'd1;
                // End of an sck-high clk: sample miso, present the next mosi bit.
                if (cnt_r[0]) begin
                    tx_s   = {tx_r[30:0], 1'b0};
                    mosi_s = tx_r[30];
                    if (cnt_r[6]) begin
                        rx_s = {rx_r[30:0], spi_miso};
                    end else begin
                        rx_s = rx_r;
                    end
                end else begin
                    tx_s = tx_r;
                end
                if (cnt_r == 7'd127) begin
                    state_s = HOLD;
                end else begin
                    state_s = SHIFT;
                end
            end
            HOLD: begin
                state_s  = DONE;
                hrdata_s = byte_swap(rx_r);
            end
            ERR0: begin
                state_s = ERR1;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        cs_n_s        = !(state_s inside {SETUP, SHIFT, HOLD});
        sck_s         = (state_s == SHIFT) && cnt_s[0];
        hready_resp_s = !(state_s inside {SETUP, SHIFT, HOLD, ERR0});
        hresp_s       = state_s inside {ERR0, ERR1};
    end

    // State, datapath and output flops; reset aborts any frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= 7'd0;
            tx_r          <= 32'd0;
            rx_r          <= 32'd0;
            hrdata_r      <= 32'd0;
            cs_n_r        <= 1'b1;
            sck_r         <= 1'b0;
            mosi_r        <= 1'b0;
            hready_resp_r <= 1'b1;
            hresp_r       <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            tx_r          <= tx_s;
            rx_r          <= rx_s;
            hrdata_r      <= hrdata_s;
            cs_n_r        <= cs_n_s;
            sck_r         <= sck_s;
            mosi_r        <= mosi_s;
            hready_resp_r <= hready_resp_s;
            hresp_r       <= hresp_s;
        end
    end

    assign ahbls_hready_resp = hready_resp_r;
    assign ahbls_hresp       = hresp_r;
    assign ahbls_hrdata      = hrdata_r;
    assign spi_cs_n          = cs_n_r;
    assign spi_sck           = sck_r;
    assign spi_mosi          = mosi_r;

endmodule
